// File: rtl/mm_read_master_if.sv
// Avalon-MM read-only bus between mm_read_master (master) and the fabric or SDRAM bridge (slave).
interface mm_read_master_if #(
  parameter int ADDRESSWIDTH    = 28,
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4
);
  logic [ADDRESSWIDTH-1:0]    address;
  logic                       read;
  logic [BYTEENABLEWIDTH-1:0] byteenable;
  logic [DATAWIDTH-1:0]       readdata;
  logic                       readdatavalid;
  logic                       waitrequest;

  modport master (
    output address, read, byteenable,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, byteenable,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/mm_read_master.sv
// Avalon-MM read master: issues word reads for a (base, length) request into a show-ahead FIFO.
// Define READ_MASTER_PIPELINE_EN to allow up to FIFODEPTH reads in flight (default: one at a time).
module mm_read_master #(
  parameter int ADDRESSWIDTH    = 28,
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int FIFODEPTH       = 8,
  parameter int FIFODEPTH_LOG2  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0] control_read_base,
  input  logic [ADDRESSWIDTH-1:0] control_read_length,
  input  logic                    control_go,
  output logic                    control_done,
  input  logic                    user_read_buffer,
  output logic [DATAWIDTH-1:0]    user_buffer_output_data,
  output logic                    user_data_available,
  mm_read_master_if.master        master
);

  localparam int CNT_W = FIFODEPTH_LOG2 + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [ADDRESSWIDTH-1:0] STRIDE     = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] ALIGN_MASK = ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
  localparam logic [CNT_W-1:0]        DEPTH_CNT  = CNT_W'(FIFODEPTH);
  localparam logic [SUM_W-1:0]        DEPTH_SUM  = SUM_W'(FIFODEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q;
  logic [ADDRESSWIDTH-1:0] remaining_q;
  logic                    fixed_q;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;

  logic [DATAWIDTH-1:0]      mem [FIFODEPTH];
  logic [FIFODEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          used_q;

  logic                    go_accept;
  logic [ADDRESSWIDTH-1:0] go_length;
  logic                    read_accept;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    space_ok;
  logic                    issue_slot;

  assign go_accept   = (state_q == IDLE) && control_go;
  assign go_length   = control_read_length & ALIGN_MASK;
  assign read_accept = master.read && !master.waitrequest;
  // Data arriving with nothing in flight belongs to reads abandoned by a reset.
  assign fifo_push   = master.readdatavalid && (outstanding_q != '0);
  assign fifo_pop    = user_read_buffer && (used_q != '0);

  // A request is only issued when its returning word already has a FIFO slot reserved.
  assign space_ok = ({1'b0, used_q} + {1'b0, outstanding_q}) < DEPTH_SUM;

`ifdef READ_MASTER_PIPELINE_EN
  assign issue_slot = 1'b1;
`else
  assign issue_slot = (outstanding_q == '0);
`endif

  assign outstanding_d = outstanding_q + CNT_W'(read_accept) - CNT_W'(fifo_push);

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (go_accept && go_length != '0) state_d = ISSUE;
      ISSUE: if (read_accept && remaining_q <= STRIDE) state_d = DRAIN;
      // Looking at the next count lets done rise the cycle after the last data word.
      DRAIN: if (outstanding_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    control_done = 1'b0;
    master.read  = 1'b0;
    unique case (state_q)
      IDLE:    control_done = 1'b1;
      ISSUE:   master.read  = (remaining_q != '0) && space_ok && issue_slot;
      DRAIN:   ;
      default: control_done = 1'b1;
    endcase
  end

  assign master.address    = addr_q;
  assign master.byteenable = '1;

  // ---------------------------------------------------------------------------
  // Request datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      fixed_q       <= 1'b0;
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (go_accept) begin
        addr_q      <= control_read_base;
        remaining_q <= go_length;
        fixed_q     <= control_fixed_location;
      end else if (read_accept) begin
        remaining_q <= remaining_q - STRIDE;
        if (!fixed_q) addr_q <= addr_q + STRIDE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead read-data FIFO
  // ---------------------------------------------------------------------------
  // NOTE: storage has no reset; pointers and used count define which words are valid.
  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr_q] <= master.readdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + FIFODEPTH_LOG2'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + FIFODEPTH_LOG2'(1);
      used_q <= used_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  assign user_data_available     = (used_q != '0);
  assign user_buffer_output_data = user_data_available ? mem[rd_ptr_q] : '0;

  // ---------------------------------------------------------------------------
  // Invariants of the space reservation scheme
  // ---------------------------------------------------------------------------
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    fifo_push |-> (used_q != DEPTH_CNT) || fifo_pop);

  a_reserved_space: assert property (@(posedge clk) disable iff (!reset)
    ({1'b0, used_q} + {1'b0, outstanding_q}) <= DEPTH_SUM);

endmodule

// File: tb/tb_mm_read_master.sv
// Scoreboarded bench for mm_read_master: Avalon slave model plus a FIFO-draining monitor.
module tb_mm_read_master;
  localparam int AW  = 28;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int FD  = 8;
  localparam int FDL = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          control_fixed_location;
  logic [AW-1:0] control_read_base;
  logic [AW-1:0] control_read_length;
  logic          control_go;
  logic          control_done;
  logic          user_read_buffer;
  logic [DW-1:0] user_buffer_output_data;
  logic          user_data_available;

  always #5 clk = ~clk;

  mm_read_master_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(BW)) bus ();

  mm_read_master #(
    .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(BW),
    .FIFODEPTH(FD), .FIFODEPTH_LOG2(FDL)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .control_fixed_location  (control_fixed_location),
    .control_read_base       (control_read_base),
    .control_read_length     (control_read_length),
    .control_go              (control_go),
    .control_done            (control_done),
    .user_read_buffer        (user_read_buffer),
    .user_buffer_output_data (user_buffer_output_data),
    .user_data_available     (user_data_available),
    .master                  (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  rsp_t          pend [$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lat = 2;
  int   accepts = 0;
  int   outst = 0;
  int   max_out = 0;
  int   wait_target = -1;
  int   wait_left = 0;
  logic [AW-1:0] stall_expect_addr = '0;
  bit   pop_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Avalon slave model: word data is 0xAAAA concatenated with the low address half.
  initial begin
    bus.readdata      = '0;
    bus.readdatavalid = 1'b0;
    bus.waitrequest   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        bus.readdatavalid = 1'b1;
        bus.readdata      = pend[0].data;
        void'(pend.pop_front());
        outst--;
      end else begin
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
      end
      if (bus.read && accepts == wait_target && wait_left > 0) begin
        bus.waitrequest = 1'b1;
        wait_left--;
        check("wait_hold_addr", bus.address, stall_expect_addr);
      end else begin
        bus.waitrequest = 1'b0;
        if (bus.read) begin
          if (exp_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL read_unexpected: address 0x%0h, none expected", bus.address);
          end else begin
            check("read_addr", bus.address, exp_addr.pop_front());
          end
          pend.push_back('{{16'hAAAA, bus.address[15:0]}, cyc + lat});
          accepts++;
          outst++;
          if (outst > max_out) max_out = outst;
        end
      end
    end
  end

  // Monitor: pops the FIFO head whenever allowed and compares it in order.
  initial begin
    user_read_buffer = 1'b0;
    forever begin
      @(negedge clk);
      if (pop_en && user_data_available) begin
        if (exp_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL data_unexpected: got 0x%0h, none expected", user_buffer_output_data);
        end else begin
          check("read_data", user_buffer_output_data, exp_data.pop_front());
        end
        user_read_buffer = 1'b1;
      end else begin
        user_read_buffer = 1'b0;
      end
    end
  end

  task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic fixed);
    logic [AW-1:0] a;
    control_read_base      = base;
    control_read_length    = len;
    control_fixed_location = fixed;
    accepts = 0;
    for (int i = 0; i < int'(len >> 2); i++) begin
      a = fixed ? base : base + AW'(4 * i);
      exp_addr.push_back(a);
      exp_data.push_back({16'hAAAA, a[15:0]});
    end
    control_go = 1'b1;
    tick();
    control_go = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(control_done && exp_data.size() == 0 && pend.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(n < budget), 64'd1);
  endtask

  initial begin
    int n;
    int need;
    reset                  = 1'b0;
    control_fixed_location = 1'b0;
    control_read_base      = '0;
    control_read_length    = '0;
    control_go             = 1'b0;
    repeat (3) tick();
    check("rst_done", control_done, 1);
    check("rst_read", bus.read, 0);
    check("rst_addr", bus.address, 0);
    check("rst_byteenable", bus.byteenable, 4'hF);
    check("rst_avail", user_data_available, 0);
    check("rst_data", user_buffer_output_data, 0);
    reset = 1'b1;
    repeat (5) tick();
    check("idle_no_read", accepts, 0);
    check("idle_done", control_done, 1);

    // Single fixed-location word; done and data rise together.
    start(28'h8000000, 28'd4, 1'b1);
    check("t1_read_next_cycle", bus.read, 1);
    check("t1_addr_next_cycle", bus.address, 28'h8000000);
    check("t1_done_low", control_done, 0);
    n = 0;
    while (!user_data_available && n < 20) begin tick(); n++; end
    check("t1_data_arrives", user_data_available, 1);
    check("t1_done_with_data", control_done, 1);
    check("t1_head_word", user_buffer_output_data, 32'hAAAA0000);
    pop_en = 1'b1;
    wait_idle("t1_idle", 20);
    tick();
    check("t1_empty_after_pop", user_data_available, 0);

    // Fixed location over two words.
    start(28'h0000200, 28'd8, 1'b1);
    wait_idle("t2_idle", 50);
    check("t2_accepts", accepts, 2);

    // 24 words with the FIFO left undrained until it fills; a mid-transfer go is ignored.
    pop_en = 1'b0;
    start(28'h8000004, 28'd96, 1'b0);
    control_read_base   = 28'h9000000;
    control_read_length = 28'd4;
    control_go = 1'b1;
    tick();
    control_go = 1'b0;
    n = 0;
    while (accepts < FD && n < 300) begin tick(); n++; end
    repeat (10) tick();
    check("t3_fill_accepts", accepts, FD);
    check("t3_stalled_read", bus.read, 0);
    check("t3_avail_full", user_data_available, 1);
    pop_en = 1'b1;
    wait_idle("t3_idle", 600);
    check("t3_total_accepts", accepts, 24);
    check("t3_addr_queue_empty", exp_addr.size(), 0);

    // Waitrequest held for three cycles on the second read.
    wait_target = 1;
    wait_left = 3;
    stall_expect_addr = 28'h0000104;
    start(28'h0000100, 28'd16, 1'b0);
    wait_idle("t4_idle", 100);
    check("t4_stall_seen", wait_left, 0);
    check("t4_accepts", accepts, 4);
    wait_target = -1;

    // Zero length does nothing; length 6 rounds down to a single word.
    start(28'h0000500, 28'd0, 1'b0);
    check("t5_zero_done", control_done, 1);
    check("t5_zero_read", bus.read, 0);
    repeat (10) tick();
    check("t5_zero_accepts", accepts, 0);
    start(28'h0000600, 28'd6, 1'b0);
    wait_idle("t5_len6_idle", 50);
    check("t5_len6_accepts", accepts, 1);

    // Asynchronous reset with reads in flight; their late data must be dropped.
    pop_en = 1'b0;
    lat = 4;
`ifdef READ_MASTER_PIPELINE_EN
    need = 3;
`else
    need = 1;
`endif
    start(28'h0000300, 28'd32, 1'b0);
    n = 0;
    while (outst < need && n < 100) begin tick(); n++; end
    check("t6_in_flight", 64'(outst >= need), 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_done", control_done, 1);
    check("t6_rst_read", bus.read, 0);
    check("t6_rst_addr", bus.address, 0);
    check("t6_rst_avail", user_data_available, 0);
    check("t6_rst_data", user_buffer_output_data, 0);
    exp_addr.delete();
    exp_data.delete();
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check("t6_stale_delivered", pend.size(), 0);
    check("t6_stale_dropped", user_data_available, 0);
    check("t6_idle_after", control_done, 1);
    lat = 2;
    pop_en = 1'b1;
    start(28'h0000400, 28'd8, 1'b0);
    wait_idle("t6_restart_idle", 50);
    check("t6_restart_accepts", accepts, 2);

`ifdef READ_MASTER_PIPELINE_EN
    check("max_outstanding", 64'(max_out <= FD), 64'd1);
`else
    check("max_outstanding", max_out, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mm_read_master.md
# mm_read_master

Avalon-MM read master that serves the user-logic read control interface: it accepts a read request (base, length, fixed/incrementing), issues word reads on the SDRAM/bridge port, and buffers returned words in a show-ahead FIFO drained by the user logic. It sits between the mining memory manager and the memory-mapped fabric and is the responder for `read_control_*` / `read_user_*`.

## Interface
- ADDRESSWIDTH, 28, byte address width of control base/length and `master_address`
- DATAWIDTH, 32, data word width
- BYTEENABLEWIDTH, 4, bytes per word (DATAWIDTH/8); address stride
- FIFODEPTH, 8, read-data FIFO depth in words (power of two, ≥2)
- FIFODEPTH_LOG2, 3, log2(FIFODEPTH)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- control_fixed_location  in  1  1: address does not increment
- control_read_base  in  ADDRESSWIDTH  start byte address
- control_read_length  in  ADDRESSWIDTH  bytes to read; low log2(BYTEENABLEWIDTH) bits ignored
- control_go  in  1  single-cycle start strobe
- control_done  out  1  high and held when idle and no reads outstanding
- user_read_buffer  in  1  pop FIFO head
- user_buffer_output_data  out  DATAWIDTH  FIFO head (valid when data_available)
- user_data_available  out  1  FIFO not empty
- master_address  out  ADDRESSWIDTH  Avalon byte address
- master_read  out  1  Avalon read request
- master_byteenable  out  BYTEENABLEWIDTH  constant all ones
- master_readdata  in  DATAWIDTH  Avalon read data
- master_readdatavalid  in  1  read data valid
- master_waitrequest  in  1  slave stall

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: `control_done`=1. On `control_go`: latch base into address register, remaining = length with low bits cleared, latch fixed flag, `control_done`→0. remaining=0 → stay IDLE, `control_done` remains 1. Else → ISSUE.
- `control_go` outside IDLE ignored; latched parameters unchanged.
- ISSUE: `master_read`=1 when remaining≠0 and (fifo_used + outstanding) < FIFODEPTH. Request accepted on cycle with `master_read`=1 and `master_waitrequest`=0: outstanding+1, remaining−BYTEENABLEWIDTH, address+BYTEENABLEWIDTH unless fixed. Address/read held stable while waitrequest=1. remaining reaches 0 on accept → DRAIN.
- DRAIN: no requests; when outstanding=0 → IDLE.
- Each `master_readdatavalid` writes `master_readdata` into FIFO, outstanding−1. Space reservation guarantees no overflow; readdatavalid never dropped.
- FIFO: show-ahead; push and pop same cycle allowed (used unchanged). Pop when empty ignored. FIFO not flushed by `control_go`; leftover words persist.
- Pointers wrap modulo FIFODEPTH; used counter FIFODEPTH_LOG2+1 bits.
- Reset mid-transfer: all state cleared immediately; outstanding bus reads abandoned, later readdatavalid after reset release is dropped only if outstanding=0 (counter never underflows).

## Timing
- Reset values: `control_done`=1, `master_read`=0, `master_address`=0, `master_byteenable`=all ones, `user_data_available`=0, `user_buffer_output_data`=0.
- `control_go` at edge N → `master_read` high, `master_address`=base from cycle N+1.
- Zero-wait slave: one accepted request per cycle while space permits.
- readdatavalid at cycle K → `user_data_available`=1 from K+1.
- Pop at cycle P → next word (or available=0) visible at P+1.
- Last readdatavalid at cycle L → `control_done`=1 from L+1 (data may remain in FIFO).

## Configuration
- READ_MASTER_PIPELINE_EN defined: up to FIFODEPTH reads outstanding (limited by fifo_used+outstanding).
- Undefined: at most one outstanding read; next request issued only in cycle after its readdatavalid; FIFO space rule still applies.

## Test plan
- Reset with reset=0 -> all outputs at reset values, `control_done`=1; release, no activity.
- go base=0x8000000, length=4, fixed=1, zero-wait, latency 2 -> one read at 0x8000000, data 0xAAAA0000 available, done rises cycle after readdatavalid, pop empties FIFO.
- go base=0x8000004, length=96, fixed=0, no pops until FIFO full -> 8 words buffered, `master_read` stalls; popping resumes; 24 reads at 0x8000004..0x8000060 total, data order preserved.
- waitrequest high 3 cycles on 2nd read -> address/read held stable, no duplicate accept.
- length=0 go -> no `master_read`, `control_done` stays 1; length=6 -> exactly one read.
- Async reset asserted with 3 reads outstanding -> outputs reset same cycle; new go after release completes normally; with macro undefined, never more than 1 outstanding.
